// File: rtl/txn_pkg.sv
// Shared types, default bank bases and the fabric address decoder for txn_mem_responder.
package txn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MAP  = 2'd0,
        PATH = 2'd1,
        NONE = 2'd2
    } bank_e;

    typedef struct packed {
        bank_e       bank;
        logic [31:0] word;
    } dec_t;

    localparam logic [31:0] MAP_BASE_DEF  = 32'h4000_0000;
    localparam logic [31:0] PATH_BASE_DEF = 32'h4000_2000;

    // Unsigned offsets wrap for addresses below a base, so one compare checks both ends.
    function automatic dec_t addr_decode(
        input logic [31:0] addr,
        input logic [31:0] map_base,
        input logic [31:0] path_base,
        input logic [31:0] span
    );
        logic [31:0] map_off;
        logic [31:0] path_off;
        dec_t        d;
        map_off  = addr - map_base;
        path_off = addr - path_base;
        d.bank   = NONE;
        d.word   = 32'd0;
        if (map_off < span) begin
            d.bank = MAP;
            d.word = map_off >> 2;
        end else if (path_off < span) begin
            d.bank = PATH;
            d.word = path_off >> 2;
        end else begin
            d.bank = NONE;
            d.word = 32'd0;
        end
        return d;
    endfunction

endpackage

// File: rtl/txn_bank_ram.sv
// 32-bit x DEPTH word bank: fabric side with asynchronous read, host side with registered read.
module txn_bank_ram #(
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          fab_we,
    input  logic [AW-1:0] fab_addr,
    input  logic [31:0]   fab_wdata,
    output logic [31:0]   fab_rdata,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] host_rdata_r;

    // Storage writes; the responder never enables both writers on the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (fab_we) begin
            mem_r[fab_addr] <= fab_wdata;
        end
        if (host_en && host_we) begin
            mem_r[host_addr] <= host_wdata;
        end
    end

    // Host read data register, updated only by an accepted host read.
    always_ff @(posedge clk) begin
        if (srst) begin
            host_rdata_r <= 32'd0;
        end else if (host_en && !host_we) begin
            host_rdata_r <= mem_r[host_addr];
        end
    end

    assign fab_rdata  = mem_r[fab_addr];
    assign host_rdata = host_rdata_r;

endmodule

// File: rtl/txn_mem_responder.sv
// Fabric txn_* responder over MAP/PATH word banks with a host preload/readback port.
// Optional macro TXN_ERR_RESP_EN adds txn_err and err_sticky outputs.
module txn_mem_responder
    import txn_pkg::*;
#(
    parameter  int          DEPTH     = 128,
    parameter  int          LATENCY   = 4,
    parameter  logic [31:0] MAP_BASE  = MAP_BASE_DEF,
    parameter  logic [31:0] PATH_BASE = PATH_BASE_DEF,
    localparam int          AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          txn_req,
    input  logic          txn_wr,
    input  logic [31:0]   txn_addr,
    input  logic [31:0]   txn_wdata,
    output logic [31:0]   txn_rdata,
    output logic          txn_rdy,
    input  logic          host_en,
    input  logic          host_we,
    input  logic          host_sel,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_ack
`ifdef TXN_ERR_RESP_EN
    ,
    output logic          txn_err,
    output logic          err_sticky
`endif
);

    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;
    localparam logic [4:0]  LAT  = 5'(LATENCY);

    state_e        state_r;
    bank_e         bank_r;
    logic [4:0]    cnt_r;
    logic [AW-1:0] idx_r;
    logic [31:0]   wdata_r;
    logic [31:0]   txn_rdata_r;
    logic          txn_rdy_r;
    logic          host_sel_r;

    dec_t          dec_s;
    logic          unused_s;
    logic          complete_s;
    logic          conflict_s;
    logic          host_ack_s;
    logic          path_fab_we_s;
    logic [31:0]   fab_rd_s;
    logic [31:0]   map_fab_rdata_s;
    logic [31:0]   path_fab_rdata_s;
    logic [31:0]   map_host_rdata_s;
    logic [31:0]   path_host_rdata_s;

    assign dec_s    = addr_decode(txn_addr, MAP_BASE, PATH_BASE, SPAN);
    assign unused_s = &{1'b0, dec_s.word[31:AW]};

    assign complete_s    = (state_r != IDLE) && (cnt_r == 5'd0);
    assign conflict_s    = complete_s &&
                           (((bank_r == MAP) && !host_sel) || ((bank_r == PATH) && host_sel));
    assign host_ack_s    = host_en && !conflict_s;
    // A completion coinciding with srst is aborted, so its PATH write must not land.
    assign path_fab_we_s = complete_s && (state_r == WR_WAIT) && (bank_r == PATH) && !srst;

    // Fabric read data selected by the bank latched at request time.
    always_comb begin
        fab_rd_s = 32'd0;
        case (bank_r)
            MAP:     fab_rd_s = map_fab_rdata_s;
            PATH:    fab_rd_s = path_fab_rdata_s;
            default: fab_rd_s = 32'd0;
        endcase
    end

`ifdef TXN_ERR_RESP_EN
    logic txn_err_r;
    logic err_sticky_r;
    logic bad_s;

    assign bad_s = (bank_r == NONE) || ((state_r == WR_WAIT) && (bank_r == MAP));

    // Error status captured at each completion; the sticky copy only clears on srst.
    always_ff @(posedge clk) begin
        if (srst) begin
            txn_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
        end else if (complete_s) begin
            txn_err_r    <= bad_s;
            err_sticky_r <= err_sticky_r | bad_s;
        end
    end

    assign txn_err    = txn_err_r;
    assign err_sticky = err_sticky_r;
`endif

    // Fabric transaction FSM: accept in IDLE, count down LATENCY wait cycles, then complete.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= IDLE;
            bank_r      <= NONE;
            cnt_r       <= 5'd0;
            idx_r       <= '0;
            wdata_r     <= 32'd0;
            txn_rdata_r <= 32'd0;
            txn_rdy_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (txn_req) begin
                        bank_r    <= dec_s.bank;
                        idx_r     <= dec_s.word[AW-1:0];
                        cnt_r     <= LAT;
                        txn_rdy_r <= 1'b0;
                        if (txn_wr) begin
                            wdata_r <= txn_wdata;
                            state_r <= WR_WAIT;
                        end else begin
                            state_r <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end else begin
                        if (state_r == RD_WAIT) begin
                            txn_rdata_r <= fab_rd_s;
                        end
                        txn_rdy_r <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    txn_rdy_r <= 1'b1;
                end
            endcase
        end
    end

    // Remembers which bank the last accepted host read targeted for the output mux.
    always_ff @(posedge clk) begin
        if (srst) begin
            host_sel_r <= 1'b0;
        end else if (host_ack_s && !host_we) begin
            host_sel_r <= host_sel;
        end
    end

    txn_bank_ram #(.DEPTH(DEPTH)) u_map (
        .clk        (clk),
        .srst       (srst),
        .fab_we     (1'b0),
        .fab_addr   (idx_r),
        .fab_wdata  (32'd0),
        .fab_rdata  (map_fab_rdata_s),
        .host_en    (host_ack_s && !host_sel),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (map_host_rdata_s)
    );

    txn_bank_ram #(.DEPTH(DEPTH)) u_path (
        .clk        (clk),
        .srst       (srst),
        .fab_we     (path_fab_we_s),
        .fab_addr   (idx_r),
        .fab_wdata  (wdata_r),
        .fab_rdata  (path_fab_rdata_s),
        .host_en    (host_ack_s && host_sel),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (path_host_rdata_s)
    );

    assign txn_rdata  = txn_rdata_r;
    assign txn_rdy    = txn_rdy_r;
    assign host_ack   = host_ack_s;
    assign host_rdata = host_sel_r ? path_host_rdata_s : map_host_rdata_s;

endmodule

// File: tb/tb_txn_mem_responder.sv
// Self-checking bench for txn_mem_responder: directed table, corner sequences, random vs. array model.
module tb_txn_mem_responder;

    localparam int          DEPTH  = 128;
    localparam int          LAT    = 4;
    localparam logic [31:0] MAP_B  = 32'h4000_0000;
    localparam logic [31:0] PATH_B = 32'h4000_2000;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        txn_req = 1'b0;
    logic        txn_wr = 1'b0;
    logic [31:0] txn_addr = 32'd0;
    logic [31:0] txn_wdata = 32'd0;
    logic [31:0] txn_rdata;
    logic        txn_rdy;
    logic        host_en = 1'b0;
    logic        host_we = 1'b0;
    logic        host_sel = 1'b0;
    logic [6:0]  host_addr = 7'd0;
    logic [31:0] host_wdata = 32'd0;
    logic [31:0] host_rdata;
    logic        host_ack;
`ifdef TXN_ERR_RESP_EN
    logic        txn_err;
    logic        err_sticky;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] map_m  [DEPTH];
    logic [31:0] path_m [DEPTH];
    logic [31:0] rdata_m = 32'd0;
    bit          sticky_m = 1'b0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;
    vec_t tbl [12];

    txn_mem_responder dut (
        .clk        (clk),
        .srst       (srst),
        .txn_req    (txn_req),
        .txn_wr     (txn_wr),
        .txn_addr   (txn_addr),
        .txn_wdata  (txn_wdata),
        .txn_rdata  (txn_rdata),
        .txn_rdy    (txn_rdy),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_sel   (host_sel),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack)
`ifdef TXN_ERR_RESP_EN
        ,
        .txn_err    (txn_err),
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // 0 = MAP, 1 = PATH, 2 = unmapped
    function automatic int region_of(input logic [31:0] a);
        if (a >= MAP_B && a < MAP_B + 32'(DEPTH * 4)) return 0;
        if (a >= PATH_B && a < PATH_B + 32'(DEPTH * 4)) return 1;
        return 2;
    endfunction

    function automatic int index_of(input logic [31:0] a, input int rgn);
        if (rgn == 0) return int'((a - MAP_B) / 32'd4);
        return int'((a - PATH_B) / 32'd4);
    endfunction

    task automatic host_write(input logic sel, input int a, input logic [31:0] d);
        host_en = 1'b1; host_we = 1'b1; host_sel = sel; host_addr = 7'(a); host_wdata = d;
        #1;
        check("host_ack_wr", 32'(host_ack), 32'd1);
        cyc();
        host_en = 1'b0; host_we = 1'b0;
        if (sel) path_m[a] = d; else map_m[a] = d;
    endtask

    task automatic host_read(input logic sel, input int a);
        host_en = 1'b1; host_we = 1'b0; host_sel = sel; host_addr = 7'(a);
        #1;
        check("host_ack_rd", 32'(host_ack), 32'd1);
        cyc();
        host_en = 1'b0;
        check("host_rdata", host_rdata, sel ? path_m[a] : map_m[a]);
    endtask

    task automatic model_err(input bit e);
`ifdef TXN_ERR_RESP_EN
        sticky_m = sticky_m | e;
        check("txn_err", 32'(txn_err), 32'(e));
        check("err_sticky", 32'(err_sticky), 32'(sticky_m));
`else
        if (e) sticky_m = 1'b1;
`endif
    endtask

    task automatic fabric_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] got_rdata, output bit exp_err);
        int rgn;
        int n;
        rgn = region_of(addr);
        txn_req = 1'b1; txn_wr = wr; txn_addr = addr; txn_wdata = wdata;
        cyc();
        txn_req = 1'b0;
        n = 0;
        while (txn_rdy !== 1'b1 && n < 64) begin
            n++;
            cyc();
        end
        check("busy_len", 32'(n), 32'(LAT + 1));
        if (wr) begin
            if (rgn == 1) path_m[index_of(addr, rgn)] = wdata;
            exp_err = (rgn != 1);
        end else begin
            if (rgn == 0)      rdata_m = map_m[index_of(addr, rgn)];
            else if (rgn == 1) rdata_m = path_m[index_of(addr, rgn)];
            else               rdata_m = 32'd0;
            exp_err = (rgn == 2);
        end
        check("txn_rdata", txn_rdata, rdata_m);
        model_err(exp_err);
        got_rdata = txn_rdata;
    endtask

    initial begin
        logic [31:0] got;
        bit          e;
        int          n1;
        int          n2;
        logic [31:0] a;
        logic [31:0] old3;

        // Reset
        repeat (3) cyc();
        check("rst_rdy", 32'(txn_rdy), 32'd1);
        check("rst_rdata", txn_rdata, 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
`ifdef TXN_ERR_RESP_EN
        check("rst_txn_err", 32'(txn_err), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
`endif
        srst = 1'b0;
        cyc();

        // Preload both banks so no uninitialised word is ever read
        for (int i = 0; i < DEPTH; i++) host_write(1'b0, i, $urandom());
        for (int i = 0; i < DEPTH; i++) host_write(1'b1, i, $urandom());

        // Test 1: host write then read MAP[1]
        host_write(1'b0, 1, 32'h0000_0105);
        host_read(1'b0, 1);
        host_write(1'b0, 4, 32'h0000_0404);
        host_write(1'b0, 127, 32'h0000_7F7F);

        // Test 2 and 3
        fabric_txn(1'b0, 32'h4000_0004, 32'd0, got, e);
        check("t2_rdata", got, 32'h0000_0105);
        fabric_txn(1'b1, 32'h4000_2008, 32'hCAFE_0001, got, e);
        host_read(1'b1, 2);
        check("t3_path2", host_rdata, 32'hCAFE_0001);

        // Directed table including range boundaries and ignored MAP write
        tbl[0]  = '{1'b0, 32'h4000_0004, 32'd0,          32'h0000_0105, 1'b0};
        tbl[1]  = '{1'b0, 32'h4000_2008, 32'd0,          32'hCAFE_0001, 1'b0};
        tbl[2]  = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF,  32'hCAFE_0001, 1'b1};
        tbl[3]  = '{1'b0, 32'h4000_0010, 32'd0,          32'h0000_0404, 1'b0};
        tbl[4]  = '{1'b0, 32'h4000_0200, 32'd0,          32'h0000_0000, 1'b1};
        tbl[5]  = '{1'b0, 32'h4000_01FF, 32'd0,          32'h0000_7F7F, 1'b0};
        tbl[6]  = '{1'b1, 32'h4000_21FC, 32'h1234_5678,  32'h0000_7F7F, 1'b0};
        tbl[7]  = '{1'b0, 32'h4000_21FE, 32'd0,          32'h1234_5678, 1'b0};
        tbl[8]  = '{1'b0, 32'h3FFF_FFFC, 32'd0,          32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b1, 32'h5000_0000, 32'h0000_0BAD,  32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 32'h4000_2200, 32'd0,          32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 32'h4000_1FFC, 32'd0,          32'h0000_0000, 1'b1};
        for (int i = 0; i < 12; i++) begin
            fabric_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, got, e);
            check($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end

        // Test 4: request held through a busy read, re-accepted on the rdy-high cycle
        txn_req = 1'b1; txn_wr = 1'b0; txn_addr = 32'h4000_0004;
        cyc();
        n1 = 0;
        while (txn_rdy !== 1'b1 && n1 < 64) begin n1++; cyc(); end
        cyc();
        txn_req = 1'b0;
        n2 = 0;
        while (txn_rdy !== 1'b1 && n2 < 64) begin n2++; cyc(); end
        check("t4_first_window", 32'(n1), 32'(LAT + 1));
        check("t4_second_window", 32'(n2), 32'(LAT + 1));
        rdata_m = map_m[1];
        check("t4_rdata", txn_rdata, rdata_m);

        // Test 5: host read of PATH conflicts with fabric PATH write completion
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = PATH_B + 32'd8; txn_wdata = 32'hBEEF_0002;
        cyc();
        txn_req = 1'b0;
        repeat (LAT) begin
            check("t5_busy", 32'(txn_rdy), 32'd0);
            cyc();
        end
        check("t5_busy_last", 32'(txn_rdy), 32'd0);
        host_en = 1'b1; host_we = 1'b0; host_sel = 1'b1; host_addr = 7'd2;
        #1;
        check("t5_ack_conflict", 32'(host_ack), 32'd0);
        cyc();
        path_m[2] = 32'hBEEF_0002;
        check("t5_rdy", 32'(txn_rdy), 32'd1);
        check("t5_ack_next", 32'(host_ack), 32'd1);
        cyc();
        host_en = 1'b0;
        check("t5_host_rdata", host_rdata, 32'hBEEF_0002);
        model_err(1'b0);

        // Host PATH write alongside fabric MAP read completion: both proceed
        txn_req = 1'b1; txn_wr = 1'b0; txn_addr = MAP_B + 32'd16;
        cyc();
        txn_req = 1'b0;
        repeat (LAT) cyc();
        host_en = 1'b1; host_we = 1'b1; host_sel = 1'b1; host_addr = 7'd9; host_wdata = 32'h9999_0009;
        #1;
        check("t5b_ack", 32'(host_ack), 32'd1);
        cyc();
        host_en = 1'b0; host_we = 1'b0;
        path_m[9] = 32'h9999_0009;
        rdata_m = map_m[4];
        check("t5b_rdy", 32'(txn_rdy), 32'd1);
        check("t5b_rdata", txn_rdata, rdata_m);
        host_read(1'b1, 9);

        // Test 6: unmapped read, then srst aborts an in-flight read and a completing write
        fabric_txn(1'b0, 32'h5000_0000, 32'd0, got, e);
        check("t6_unmapped", got, 32'd0);
        txn_req = 1'b1; txn_wr = 1'b0; txn_addr = 32'h5000_0000;
        cyc();
        txn_req = 1'b0;
        cyc();
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        rdata_m = 32'd0; sticky_m = 1'b0;
        check("t6_rdy_after_srst", 32'(txn_rdy), 32'd1);
        check("t6_rdata_after_srst", txn_rdata, 32'd0);
`ifdef TXN_ERR_RESP_EN
        check("t6_err_after_srst", 32'(txn_err), 32'd0);
        check("t6_sticky_after_srst", 32'(err_sticky), 32'd0);
`endif
        old3 = path_m[3];
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = PATH_B + 32'd12; txn_wdata = ~old3;
        cyc();
        txn_req = 1'b0;
        repeat (LAT) cyc();
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        check("t6_rdy_drop", 32'(txn_rdy), 32'd1);
        cyc();
        check("t6_rdy_stays", 32'(txn_rdy), 32'd1);
        host_read(1'b1, 3);
        check("t6_path3_unchanged", host_rdata, old3);

        // Random mix of fabric transactions and host accesses against the array model
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    case ($urandom_range(0, 3))
                        0: a = MAP_B + 32'($urandom_range(0, DEPTH * 4 - 1));
                        1: a = PATH_B + 32'($urandom_range(0, DEPTH * 4 - 1));
                        2: a = $urandom();
                        default: a = ($urandom_range(0, 1) == 1) ? PATH_B + 32'(DEPTH * 4) : MAP_B - 32'd4;
                    endcase
                    fabric_txn(1'($urandom_range(0, 1)), a, $urandom(), got, e);
                end
                2: host_write(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom());
                default: host_read(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/txn_mem_responder.md
Name: txn_mem_responder

Overview:
Synthesizable responder for the fabric's txn_* transaction interface. It serves fabric reads and writes from two on-chip word banks:
- MAP bank: cost map, read-only from the fabric side.
- PATH bank: path results, written by the fabric.
A host-side port preloads MAP and reads back PATH. The block sits between fabric and the SoC host bus, replacing the off-chip memory path in FPGA builds.

Parameters:
DEPTH, 128, words per bank (power of two); AW = $clog2(DEPTH)
LATENCY, 4, wait cycles counted before an access completes (0..31)
MAP_BASE, 32'h40000000, byte base address of MAP bank
PATH_BASE, 32'h40002000, byte base address of PATH bank

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
txn_req  in  1  fabric request, sampled only while txn_rdy=1
txn_wr  in  1  1=write, 0=read
txn_addr  in  32  byte address
txn_wdata  in  32  write data
txn_rdata  out  32  read data, valid when txn_rdy rises after a read
txn_rdy  out  1  idle/done indication
host_en  in  1  host access request
host_we  in  1  host write
host_sel  in  1  0=MAP, 1=PATH
host_addr  in  AW  word index
host_wdata  in  32  host write data
host_rdata  out  32  host read data, one cycle after accepted read
host_ack  out  1  host access accepted this cycle

Behaviour:
- Clock and reset: single clock clk. srst is synchronous, active-high.
- Reset values: txn_rdy=1, txn_rdata=0, host_rdata=0, host_ack=0, FSM=IDLE, cnt=0. Bank contents are not reset.
- Any srst cycle aborts an in-flight access. A pending PATH write is dropped. The next cycle is IDLE with txn_rdy=1.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE: txn_rdy=1.
  - txn_req=1, txn_wr=0 → latch word index; go RD_WAIT; txn_rdy<=0; cnt<=LATENCY.
  - txn_req=1, txn_wr=1 → latch index and wdata; go WR_WAIT; txn_rdy<=0; cnt<=LATENCY.
- Word index = (txn_addr - base) >> 2. Low two address bits are ignored.
- Address hits: addr in [base, base+4*DEPTH) for MAP or PATH.
- RD_WAIT / WR_WAIT: while cnt!=0, decrement. At cnt==0 (completion cycle):
  - RD_WAIT: txn_rdata<=bank[idx].
  - WR_WAIT: PATH[idx]<=wdata.
  - Both: txn_rdy<=1; return to IDLE.
- Latency: txn_rdy is low for exactly LATENCY+1 cycles per transaction. A new request can be accepted on the first cycle txn_rdy is high again. txn_rdata holds until the next read completes.
- txn_req while txn_rdy=0 is ignored; no queueing.
- Fabric reads may hit MAP or PATH. Fabric writes may hit PATH only.
- A write to MAP or to an unmapped address completes normally with no storage change. A read of an unmapped address returns 0.
- Host port:
  - host_ack = host_en && !conflict.
  - conflict = FSM is in its completion cycle and the fabric bank equals host_sel.
  - When conflicted, the fabric wins and the host must hold its request.
  - Accepted write updates bank[host_addr] at the same edge.
  - Accepted read: host_rdata is valid the next cycle.
  - The host may write both banks.
- Same-cycle host write and fabric read completion on different banks both proceed.

Optional Feature:
Macro TXN_ERR_RESP_EN.
- Defined: adds output txn_err (1 bit, reset 0). txn_err is registered with txn_rdy at completion:
  - 1 for unmapped addresses and for writes to MAP;
  - 0 otherwise;
  - held until the next completion.
- Also adds a sticky host-readable output err_sticky, cleared only by srst.
- Not defined: no txn_err or err_sticky ports. Bad accesses are silently dropped, and unmapped reads return 0.

Decomposition:
- Package txn_pkg holds:
  - FSM state enum (IDLE, RD_WAIT, WR_WAIT);
  - bank-select enum (MAP, PATH, NONE);
  - default base-address localparams;
  - an address-decode function returning bank and index.
- Sub-module txn_bank_ram: one-port-per-side 32-bit x DEPTH RAM, instantiated twice (MAP, PATH), with a registered host read.

Test Plan:
1. Reset → txn_rdy=1, txn_rdata=0, host_ack=0. Host writes MAP[1]=32'h0000_0105 → host_ack=1; host read the next cycle → host_rdata=32'h105.
2. Fabric read at addr 32'h40000004 with LATENCY=4 → txn_rdy low for exactly 5 cycles, then rises with txn_rdata=32'h105.
3. Fabric write of 32'hCAFE_0001 to 32'h40002008 → after 5 busy cycles, host read PATH[2] returns 32'hCAFE0001.
4. txn_req held high during a busy read → ignored. Back-to-back request on the rdy-high cycle → accepted; two separate 5-cycle windows observed.
5. Host read of PATH[2] in the same completion cycle as a fabric write to PATH → host_ack=0 that cycle, 1 the next; host_rdata=new data.
6. Fabric read of 32'h50000000, then srst asserted mid-RD_WAIT → read returns 0 (txn_err=1 with TXN_ERR_RESP_EN). After srst, txn_rdy=1 the next cycle and no PATH change.
